// File: rtl/div_pkg.sv
// Shared types and constants for the divider request front-end.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } div_state_e;

    // Widest tag a request can carry; narrower TAGW values are zero-extended.
    localparam int unsigned DIV_TAG_MAXW = 16;

    localparam logic [31:0] DIV_DZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0]             dividend;
        logic [31:0]             divisor;
        logic                    sign;
        logic [DIV_TAG_MAXW-1:0] tag;
    } div_req_t;

    function automatic logic div_is_zero(input div_req_t r);
        return r.divisor == '0;
    endfunction

endpackage

// File: rtl/div_frontend_if.sv
// Request and response channels between the issue logic and the divider front-end.
interface div_frontend_if #(
    parameter int unsigned TAGW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_dividend;
    logic [31:0]     req_divisor;
    logic            req_sign;
    logic [TAGW-1:0] req_tag;

    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_quotient;
    logic [31:0]     resp_remainder;
    logic [TAGW-1:0] resp_tag;
    logic            resp_dz;

    modport master (
        output req_valid, req_dividend, req_divisor, req_sign, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_tag, resp_dz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_sign, req_tag, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_remainder, resp_tag, resp_dz
    );
endinterface

// File: rtl/div_req_fifo.sv
// Synchronous FIFO of divide requests; pointers carry an extra wrap bit to tell full from empty.
module div_req_fifo
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  div_req_t wdata,
    input  logic     pop,
    output div_req_t head,
    output logic     full,
    output logic     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    div_req_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_comb begin
        head  = mem[rd_ptr[AW-1:0]];
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

endmodule

// File: rtl/div_frontend.sv
// Buffers tagged divide requests and issues them one at a time to the sequential divider core,
// resolving divide-by-zero locally and returning results on a valid/ready channel.
module div_frontend
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    div_frontend_if.slave        bus,
    output logic [31:0]          div_dividend,
    output logic [31:0]          div_divider,
    output logic                 div_sign,
    input  logic                 div_ready,
    input  logic [31:0]          div_quotient,
    input  logic [31:0]          div_remainder
);
    div_state_e state_q, state_d;

    div_req_t req_in, head;
    logic     full, empty, push, pop, head_dz;
    logic     load_dz, load_op, capture;

    logic [TAGW-1:0] tag_q;
    logic [31:0]     resp_quotient_q, resp_remainder_q;
    logic [TAGW-1:0] resp_tag_q;
    logic            resp_dz_q;

    // Tag bits above TAGW are always zero on the way in.
    logic [DIV_TAG_MAXW-1:0] unused_tag;
    assign unused_tag = head.tag;

    always_comb begin
        req_in          = '0;
        req_in.dividend = bus.req_dividend;
        req_in.divisor  = bus.req_divisor;
        req_in.sign     = bus.req_sign;
        req_in.tag      = DIV_TAG_MAXW'(bus.req_tag);
    end

    div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req_in),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load_dz = 1'b0;
        load_op = 1'b0;
        capture = 1'b0;
        head_dz = div_is_zero(head);
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_dz) begin
                        load_dz = 1'b1;
                        state_d = RESP;
                    end else begin
                        load_op = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: if (div_ready) state_d = WAIT;
            WAIT: begin
                if (div_ready) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO can still take a request on the edge that pops its head.
    assign bus.req_ready = !full || pop;
    assign push          = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            div_dividend     <= '0;
            div_divider      <= '0;
            div_sign         <= 1'b0;
            tag_q            <= '0;
            resp_quotient_q  <= '0;
            resp_remainder_q <= '0;
            resp_tag_q       <= '0;
            resp_dz_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_op) begin
                div_dividend <= head.dividend;
                div_divider  <= head.divisor;
                div_sign     <= head.sign;
                tag_q        <= head.tag[TAGW-1:0];
            end
            if (load_dz) begin
                resp_quotient_q  <= DIV_DZ_QUOTIENT;
                resp_remainder_q <= head.dividend;
                resp_tag_q       <= head.tag[TAGW-1:0];
                resp_dz_q        <= 1'b1;
            end
            if (capture) begin
                resp_quotient_q  <= div_quotient;
                resp_remainder_q <= div_remainder;
                resp_tag_q       <= tag_q;
                resp_dz_q        <= 1'b0;
            end
        end
    end

    assign bus.resp_valid     = (state_q == RESP);
    assign bus.resp_quotient  = resp_quotient_q;
    assign bus.resp_remainder = resp_remainder_q;
    assign bus.resp_tag       = resp_tag_q;
    assign bus.resp_dz        = resp_dz_q;

endmodule

// File: tb/tb_div_frontend.sv
// Scoreboard bench for div_frontend with a behavioural model of the 32-cycle divider core.
module tb_div_frontend;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_frontend_if #(.TAGW(4)) bus_if ();

    logic [31:0] div_dividend, div_divider, div_quotient, div_remainder;
    logic        div_sign, div_ready;

    div_frontend #(.DEPTH(4), .TAGW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .div_dividend  (div_dividend),
        .div_divider   (div_divider),
        .div_sign      (div_sign),
        .div_ready     (div_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0, n_err = 0;
    int   cyc = 0, n_sent = 0, n_resp = 0, n_discard = 0;
    int   rr_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Core model: captures on every edge with ready high, result valid 32 edges later.
    logic [4:0]  core_cnt = '0;
    logic [31:0] core_q = '0, core_r = '0, last_cap_divider = '0;
    assign div_ready     = (core_cnt == 5'd0);
    assign div_quotient  = div_ready ? core_q : '0;
    assign div_remainder = div_ready ? core_r : '0;

    always @(posedge clk) begin
        if (div_ready) begin
            core_cnt         <= 5'd31;
            {core_q, core_r} <= ref_div(div_dividend, div_divider, div_sign);
            last_cap_divider <= div_divider;
        end else begin
            core_cnt <= core_cnt - 5'd1;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus_if.resp_ready = 1'b0;
            1:       bus_if.resp_ready = 1'b1;
            default: bus_if.resp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Response monitor: stability while stalled, then scoreboard compare on handshake.
    logic        in_resp = 1'b0, hold = 1'b0;
    int          t_start = 0;
    logic [68:0] held;
    always @(negedge clk) begin
        exp_t        e;
        logic [68:0] cur;
        cur = {bus_if.resp_quotient, bus_if.resp_remainder, bus_if.resp_tag, bus_if.resp_dz};
        if (rst) begin
            in_resp = 1'b0;
            hold    = 1'b0;
        end else if (bus_if.resp_valid) begin
            if (!in_resp) begin
                in_resp = 1'b1;
                t_start = cyc;
            end else if (hold) begin
                check("resp_stable", 72'(cur), 72'(held));
            end
            if (bus_if.resp_ready) begin
                n_resp++;
                if (sbq.size() == 0) begin
                    check("unexpected_resp_tag", 72'(bus_if.resp_tag), 72'hFFFF);
                end else begin
                    e = sbq.pop_front();
                    check("resp_tag", 72'(bus_if.resp_tag), 72'(e.tag));
                    check("resp_quotient", 72'(bus_if.resp_quotient), 72'(e.q));
                    check("resp_remainder", 72'(bus_if.resp_remainder), 72'(e.r));
                    check("resp_dz", 72'(bus_if.resp_dz), 72'(e.dz));
                    if (e.lat >= 0) check("resp_latency", 72'(t_start - e.acc), 72'(e.lat));
                end
                in_resp = 1'b0;
                hold    = 1'b0;
            end else begin
                hold = 1'b1;
                held = cur;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz, input int lat);
        logic ok;
        exp_t e;
        ok = 1'b0;
        bus_if.req_valid    = 1'b1;
        bus_if.req_dividend = a;
        bus_if.req_divisor  = b;
        bus_if.req_sign     = s;
        bus_if.req_tag      = t;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.req_ready) begin
                ok = 1'b1;
                e = '{q: eq, r: er, tag: t, dz: edz, lat: lat, acc: cyc + 1};
                sbq.push_back(e);
                n_sent++;
            end
            @(posedge clk);
            #1;
        end
        bus_if.req_valid = 1'b0;
        if (!ok) check("req_accept", 72'(ok), 72'(1));
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        logic [63:0] qr;
        qr = ref_div(a, b, s);
        send(a, b, s, t, qr[63:32], qr[31:0], (b == 32'd0), -1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (sbq.size() != 0 || bus_if.resp_valid); i++) @(negedge clk);
        check("drain", 72'(sbq.size()), 72'(0));
        @(posedge clk);
        #1;
    endtask

    // Place the next acceptance two edges before a core capture edge, so the core looks idle.
    task automatic align_core();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = div_ready;
        end
        check("core_ready_seen", 72'(seen), 72'(1));
        @(posedge clk);
        repeat (29) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b;
        logic        waited;
        bus_if.req_valid    = 1'b0;
        bus_if.req_dividend = '0;
        bus_if.req_divisor  = '0;
        bus_if.req_sign     = 1'b0;
        bus_if.req_tag      = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 72'(bus_if.resp_valid), 72'(0));
        check("rst_req_ready", 72'(bus_if.req_ready), 72'(1));
        check("rst_resp_quotient", 72'(bus_if.resp_quotient), 72'(0));
        check("rst_resp_remainder", 72'(bus_if.resp_remainder), 72'(0));
        check("rst_resp_tag", 72'(bus_if.resp_tag), 72'(0));
        check("rst_resp_dz", 72'(bus_if.resp_dz), 72'(0));
        check("rst_div_dividend", 72'(div_dividend), 72'(0));
        check("rst_div_divider", 72'(div_divider), 72'(0));
        check("rst_div_sign", 72'(div_sign), 72'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        rr_mode = 1;
        align_core();
        send(32'd100, 32'd7, 1'b0, 4'd3, 32'd14, 32'd2, 1'b0, 34);
        drain();
        check("div_dividend_held", 72'(div_dividend), 72'(100));
        check("div_divider_held", 72'(div_divider), 72'(7));

        align_core();
        send(32'hFFFF_FF9C, 32'd7, 1'b1, 4'd1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
        drain();

        send(32'd5, 32'd0, 1'b0, 4'd9, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        drain();

        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd2, 32'h8000_0000, 32'd0, 1'b0, -1);
        drain();

        // Backpressure: responses stalled while the FIFO fills.
        rr_mode = 0;
        for (int i = 0; i < 5; i++)
            send(32'(50 + i), 32'(i + 1), 1'b0, 4'(i), 32'((50 + i) / (i + 1)), 32'((50 + i) % (i + 1)), 1'b0, -1);
        @(negedge clk);
        check("req_ready_full", 72'(bus_if.req_ready), 72'(0));
        repeat (60) @(negedge clk);
        check("req_ready_full_resp", 72'(bus_if.req_ready), 72'(0));
        check("resp_valid_stalled", 72'(bus_if.resp_valid), 72'(1));
        @(posedge clk);
        #1 rr_mode = 2;
        drain();

        for (int i = 0; i < 8; i++) begin
            a = $urandom();
            b = (i % 4 == 3) ? 32'd0 : 32'($urandom_range(11, 5000));
            send_model(a, b, 1'($urandom_range(0, 1)), 4'(i + 4));
        end
        drain();

        // Reset while the core is mid-computation.
        rr_mode = 1;
        send(32'd1000, 32'd10, 1'b0, 4'd5, 32'd100, 32'd0, 1'b0, -1);
        waited = 1'b0;
        for (int i = 0; i < 100 && !waited; i++) begin
            @(negedge clk);
            waited = (last_cap_divider == 32'd10);
        end
        check("wait_entered", 72'(waited), 72'(1));
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        n_discard = n_discard + sbq.size();
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", 72'(bus_if.resp_valid), 72'(0));
        check("midrst_req_ready", 72'(bus_if.req_ready), 72'(1));
        @(posedge clk);
        #1;
        send(32'd20, 32'd3, 1'b0, 4'd6, 32'd6, 32'd2, 1'b0, -1);
        drain();
        repeat (40) @(negedge clk);
        check("resp_count", 72'(n_resp + n_discard), 72'(n_sent));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
